// File: rtl/adc_buf_pkg.sv
// rtl/adc_buf_pkg.sv - shared state type and stored-word width helper for adc_sample_buffer
//
// Build option: ADC_BUF_TIMESTAMP_EN
//   defined   : each stored word is {time, sig}
//   undefined : each stored word is sig only
package adc_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } adc_buf_state_t;

`ifdef ADC_BUF_TIMESTAMP_EN
  localparam bit timestamp_en = 1'b1;
`else
  localparam bit timestamp_en = 1'b0;
`endif

  // Width of one RAM word for the selected build.
  function automatic int word_bits(input int sig_bits, input int time_bits);
    return timestamp_en ? (sig_bits + time_bits) : sig_bits;
  endfunction

endpackage

// File: rtl/adc_sample_buffer_sdp_ram.sv
// rtl/adc_sample_buffer_sdp_ram.sv - simple dual-port RAM with registered read
//
// Module sdp_ram: one write port and one read port on a single clock.
// The read is registered (latency 1) and the array has no reset, so the
// structure maps onto block RAM.
//
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data updates on the following edge
//   rd_addr  : read address
//   rd_data  : registered read data, held while rd_en is low
module sdp_ram #(
  parameter int width = 16,
  parameter int depth = 1024,
  localparam int addr_bits = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] wr_addr,
  input  logic [width-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [addr_bits-1:0] rd_addr,
  output logic [width-1:0]     rd_data
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/adc_sample_buffer.sv
// rtl/adc_sample_buffer.sv - triggered capture buffer with valid/ready readout
//
// Records depth decimated samples after an arm pulse, then drains them in
// index order over a valid/ready port. Build option ADC_BUF_TIMESTAMP_EN adds
// the timestamp to each stored word; without it out_time is tied to 0.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   time_curr, sig      : input stream, registered every cycle
//   arm                 : capture start request, honoured only in IDLE
//   decim               : keep one sample every decim+1 cycles, latched at arm
//   busy                : high while capturing or draining
//   done                : one-cycle pulse with the last transfer
//   out_valid/out_ready : readout handshake
//   out_sig, out_time   : stored sample and timestamp
//   out_last            : marks word index depth-1
module adc_sample_buffer
  import adc_buf_pkg::*;
#(
  parameter int sig_bits   = 16,
  parameter int sig_point  = 14,
  parameter int time_bits  = 32,
  parameter int time_point = 0,
  parameter int depth      = 1024,
  parameter int decim_bits = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [time_bits-1:0]        time_curr,
  input  logic signed [sig_bits-1:0]  sig,
  input  logic                        arm,
  input  logic [decim_bits-1:0]       decim,
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [sig_bits-1:0]  out_sig,
  output logic [time_bits-1:0]        out_time,
  output logic                        out_last
);

  localparam int ptr_bits = $clog2(depth);
  localparam int wbits    = word_bits(sig_bits, time_bits);
  localparam logic [ptr_bits-1:0] last_idx = ptr_bits'(depth - 1);
  // Binary points describe the number format only.
  localparam int unused_points = sig_point + time_point;

  // ---------------------------------------------------------------- input stage
  logic signed [sig_bits-1:0] sig_q;
  logic [wbits-1:0]           wr_word;

`ifdef ADC_BUF_TIMESTAMP_EN
  logic [time_bits-1:0] time_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q  <= '0;
      time_q <= '0;
    end else begin
      sig_q  <= sig;
      time_q <= time_curr;
    end
  end

  assign wr_word = {time_q, sig_q};
`else
  logic unused_time;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig;
    end
  end

  assign wr_word     = sig_q;
  assign unused_time = ^time_curr;
`endif

  // ---------------------------------------------------------------- state
  adc_buf_state_t        state;
  logic [decim_bits-1:0] decim_q;
  logic [decim_bits-1:0] dcnt;
  logic [ptr_bits-1:0]   wptr;
  logic [ptr_bits-1:0]   rptr;
  logic                  wr_en_q;
  logic [ptr_bits-1:0]   wr_addr_q;
  logic                  rd_pend;
  logic                  rd_pend_last;
  logic                  rd_all;
  logic                  skid_valid;
  logic                  skid_last;
  logic [wbits-1:0]      skid_word;
  logic [wbits-1:0]      out_word;
  logic [wbits-1:0]      rd_word;

  logic       pop;
  logic [1:0] held;
  logic       rd_issue;

  // Words that will sit in the output register and skid slot after this edge.
  // A read issued now lands one edge later, so it is only issued if at least
  // one of the two slots will still be free then. Holding ready high keeps
  // held at 1 and gives one read (and one transfer) per cycle.
  assign pop      = out_valid && out_ready;
  assign held     = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
  assign rd_issue = (state == DRAIN) && !rd_all && (held <= 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      decim_q      <= '0;
      dcnt         <= '0;
      wptr         <= '0;
      rptr         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      rd_all       <= 1'b0;
      skid_valid   <= 1'b0;
      skid_last    <= 1'b0;
      skid_word    <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_word     <= '0;
    end else begin
      done    <= 1'b0;
      wr_en_q <= 1'b0;

      // RAM read side
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (rptr == last_idx);
      if (rd_issue) begin
        rptr <= rptr + 1'b1;
        if (rptr == last_idx) begin
          rd_all <= 1'b1;
        end
      end

      // Output register refills from the skid slot first, so order is kept.
      if (!out_valid || pop) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_word   <= skid_word;
          out_last   <= skid_last;
          skid_valid <= rd_pend;
          skid_word  <= rd_word;
          skid_last  <= rd_pend_last;
        end else if (rd_pend) begin
          out_valid <= 1'b1;
          out_word  <= rd_word;
          out_last  <= rd_pend_last;
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_valid <= 1'b1;
        skid_word  <= rd_word;
        skid_last  <= rd_pend_last;
      end

      case (state)
        IDLE: begin
          if (arm) begin
            state   <= CAPTURE;
            busy    <= 1'b1;
            decim_q <= decim;
            dcnt    <= '0;
            wptr    <= '0;
            rptr    <= '0;
            rd_all  <= 1'b0;
          end
        end
        CAPTURE: begin
          dcnt <= (dcnt == decim_q) ? '0 : dcnt + 1'b1;
          // The write itself lands one edge later, when sig_q holds the
          // sample that was present on this edge.
          if (dcnt == '0) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wptr;
            wptr      <= wptr + 1'b1;
            if (wptr == last_idx) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sdp_ram #(
    .width (wbits),
    .depth (depth)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_word),
    .rd_en   (rd_issue),
    .rd_addr (rptr),
    .rd_data (rd_word)
  );

  assign out_sig = out_word[sig_bits-1:0];
`ifdef ADC_BUF_TIMESTAMP_EN
  assign out_time = out_word[wbits-1:sig_bits];
`else
  assign out_time = '0;
`endif

endmodule

// File: tb/tb_adc_sample_buffer.sv
// tb/tb_adc_sample_buffer.sv - self-checking bench for adc_sample_buffer
module tb_adc_sample_buffer;

  localparam int SB    = 16;
  localparam int TW    = 32;
  localparam int DEPTH = 8;
  localparam int DB    = 8;
`ifdef ADC_BUF_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [TW-1:0]        time_curr = '0;
  logic signed [SB-1:0] sig = '0;
  logic                 arm = 1'b0;
  logic [DB-1:0]        decim = '0;
  logic                 out_ready = 1'b0;
  logic                 busy;
  logic                 done;
  logic                 out_valid;
  logic signed [SB-1:0] out_sig;
  logic [TW-1:0]        out_time;
  logic                 out_last;

  int checks = 0;
  int errors = 0;

  // stimulus control
  int edge_no = 0;
  int t0 = 0;
  bit ramp = 1'b1;
  int rdy_mode = 0;
  bit arm_noise = 1'b0;
  bit decim_noise = 1'b0;

  // behavioural model: 0 idle, 1 capturing, 2 draining
  int m_state = 0;
  int m_dec = 0;
  int m_k = 0;
  int ridx = 0;
  logic [SB-1:0] exp_sig[$];
  logic [TW-1:0] exp_time[$];
  logic [SB-1:0] got_sig[$];
  logic [TW-1:0] got_time[$];
  bit exp_done = 1'b0;
  bit exp_rst = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_xfer = 1'b0;
  logic [63:0] prev_word = '0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  adc_sample_buffer #(
    .sig_bits   (SB),
    .sig_point  (14),
    .time_bits  (TW),
    .time_point (0),
    .depth      (DEPTH),
    .decim_bits (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .time_curr (time_curr),
    .sig       (sig),
    .arm       (arm),
    .decim     (decim),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sig   (out_sig),
    .out_time  (out_time),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_no++;
    #1;
    arm = 1'b0;
    if (ramp) begin
      sig       = SB'(edge_no + 1 - t0);
      time_curr = TW'(1000 + edge_no + 1 - t0);
    end else begin
      sig       = SB'($urandom);
      time_curr = $urandom;
    end
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (arm_noise && m_state != 0) arm = ($urandom_range(0, 2) == 0);
    if (decim_noise) decim = DB'($urandom_range(0, 255));
  endtask

  // Checks outputs of the previous edge, then advances the model by the edge to come.
  initial begin
    bit xfer_now;
    int st_before;
    forever begin
      @(negedge clk);
      if (exp_rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sig", $unsigned(out_sig), 0);
        chk("rst_out_time", out_time, 0);
        chk("rst_out_last", out_last, 0);
        exp_rst = 1'b0;
      end
      chk("busy", busy, (m_state != 0));
      chk("done", done, exp_done);
      if (out_valid === 1'b1) chk("valid_only_in_drain", (m_state == 2 && ridx < DEPTH), 1);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_sig, out_time, out_last}, prev_word);
      end
      if (prev_xfer && rdy_mode == 0) chk("no_bubble", out_valid, 1);

      exp_done  = 1'b0;
      xfer_now  = (out_valid === 1'b1) && (out_ready === 1'b1);
      st_before = m_state;
      if (rst_n !== 1'b1) begin
        m_state    = 0;
        exp_rst    = 1'b1;
        prev_stall = 1'b0;
        prev_xfer  = 1'b0;
      end else begin
        if (xfer_now) begin
          chk("word_sig", $unsigned(out_sig), exp_sig[ridx]);
          chk("word_time", out_time, TS ? exp_time[ridx] : '0);
          chk("word_last", out_last, (ridx == DEPTH - 1));
          got_sig.push_back(out_sig);
          got_time.push_back(out_time);
          ridx++;
          xfer_cnt++;
          if (ridx == DEPTH) begin
            m_state = 0;
            exp_done = 1'b1;
            done_cnt++;
          end
        end
        prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
        prev_word  = {out_sig, out_time, out_last};
        prev_xfer  = xfer_now && (ridx < DEPTH);
        if (st_before == 1) begin
          m_k++;
          if ((m_k - 1) % (m_dec + 1) == 0) begin
            exp_sig.push_back(sig);
            exp_time.push_back(time_curr);
            if (exp_sig.size() == DEPTH) m_state = 2;
          end
        end else if (st_before == 0 && arm === 1'b1) begin
          m_state = 1;
          m_dec   = int'(decim);
          m_k     = 0;
          ridx    = 0;
          exp_sig.delete();
          exp_time.delete();
        end
      end
    end
  end

  // One capture: arm on relative edge 10, wait for done, count words and pulses.
  task automatic run_capture(input int d, input int rmode, input bit noise, input bit rnd);
    int d0;
    int x0;
    int n;
    ramp = !rnd;
    rdy_mode = rmode;
    got_sig.delete();
    got_time.delete();
    d0 = done_cnt;
    x0 = xfer_cnt;
    step();
    t0 = edge_no;
    if (ramp) begin
      sig = 1;
      time_curr = 1001;
    end
    decim = DB'(d);
    repeat (9) step();
    arm = 1'b1;
    arm_noise = noise;
    decim_noise = rnd;
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      step();
      n++;
    end
    arm_noise = 1'b0;
    decim_noise = 1'b0;
    repeat (3) step();
    chk("xfer_count", xfer_cnt - x0, DEPTH);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    int x0;
    int n;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // ramp, decim 0, ready held high
    run_capture(0, 0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ramp_sig_pin", got_sig[i], 64'(11 + i));
      chk("ramp_time_pin", got_time[i], TS ? 64'(1011 + i) : 64'd0);
    end

    // decimation by 4
    run_capture(3, 0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("decim_sig_pin", got_sig[i], 64'(11 + 4 * i));
      chk("decim_time_pin", got_time[i], TS ? 64'(1011 + 4 * i) : 64'd0);
    end

    // backpressure with random data and decimation
    repeat (3) run_capture($urandom_range(0, 5), 1, 1'b0, 1'b1);

    // arm pulses while busy
    run_capture(1, 1, 1'b1, 1'b1);

    // reset during drain after 3 words, arm coincident with reset
    ramp = 1'b0;
    rdy_mode = 0;
    d0 = done_cnt;
    x0 = xfer_cnt;
    decim = 8'd0;
    arm = 1'b1;
    step();
    n = 0;
    while (xfer_cnt - x0 < 3 && n < 200) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    arm = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("reset_abort_xfers", xfer_cnt - x0, 3);
    chk("reset_no_done", done_cnt - d0, 0);

    // full capture after the aborted one
    run_capture(2, 1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
